vpu_exec_sequencer: RTL and testbench

VPU_EXEC_SEQUENCER -- requirements
Module: vpu_exec_sequencer

---
 rtl/vpu_exec_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_vpu_exec_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_exec_sequencer.sv
// vpu_exec_sequencer
//   Sequences one decoded vector instruction at a time through
//   operand read -> read wait -> execute -> write-back.
//
//   Optional feature macro: VPU_SEQ_PERF_CNT_EN
//     defined   : perf_cnt counts completed instructions (wraps at 2^32)
//     undefined : perf_cnt is tied to zero, no counter register exists
//
//   Ports
//     clk, rst_n            clock (rising edge), synchronous active-low reset
//     req_valid/req_ready   request handshake, ready only while IDLE
//     req_rvalid/raddr      per-port read enables and source addresses
//     req_waddr             destination address
//     req_delay             execution latency in cycles
//     req_op_func           one-hot operation select
//     sram_ren/raddr/rdata  three read ports, data valid one cycle after ren
//     exec_start/op_func/opnd/result   execution unit interface
//     sram_wen/waddr/wdata  write-back port
//     done, perf_cnt        completion pulse, completed-instruction count
module vpu_exec_sequencer #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int MAX_DELAY_LG2 = 3,
  parameter int OPF_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_rvalid,
  input  logic [3*ADDR_W-1:0]      req_raddr,
  input  logic [ADDR_W-1:0]        req_waddr,
  input  logic [MAX_DELAY_LG2-1:0] req_delay,
  input  logic [OPF_W-1:0]         req_op_func,
  output logic [2:0]               sram_ren,
  output logic [3*ADDR_W-1:0]      sram_raddr,
  input  logic [3*DATA_W-1:0]      sram_rdata,
  output logic                     exec_start,
  output logic [OPF_W-1:0]         exec_op_func,
  output logic [3*DATA_W-1:0]      exec_opnd,
  input  logic [DATA_W-1:0]        exec_result,
  output logic                     sram_wen,
  output logic [ADDR_W-1:0]        sram_waddr,
  output logic [DATA_W-1:0]        sram_wdata,
  output logic                     done,
  output logic [31:0]              perf_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WRITE   = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [2:0]               rvalid_q;
  logic [3*ADDR_W-1:0]      raddr_q;
  logic [ADDR_W-1:0]        waddr_q;
  logic [MAX_DELAY_LG2-1:0] delay_q;
  logic [OPF_W-1:0]         opf_q;
  logic [3*DATA_W-1:0]      opnd_q;
  logic [MAX_DELAY_LG2-1:0] cnt_q;
  logic                     start_q;
  logic [DATA_W-1:0]        result_q;
  logic                     accept_s;

  assign accept_s = (state_q == ST_IDLE) && req_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ:    state_d = ST_WAIT_RD;
      ST_WAIT_RD: state_d = ST_EXEC;
      ST_EXEC: begin
        if (cnt_q == {MAX_DELAY_LG2{1'b0}}) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_WRITE:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request latch, operand capture, latency counter and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 3'b000;
      raddr_q  <= {(3*ADDR_W){1'b0}};
      waddr_q  <= {ADDR_W{1'b0}};
      delay_q  <= {MAX_DELAY_LG2{1'b0}};
      opf_q    <= {OPF_W{1'b0}};
      opnd_q   <= {(3*DATA_W){1'b0}};
      cnt_q    <= {MAX_DELAY_LG2{1'b0}};
      start_q  <= 1'b0;
      result_q <= {DATA_W{1'b0}};
    end else begin
      if (accept_s) begin
        rvalid_q <= req_rvalid;
        raddr_q  <= req_raddr;
        waddr_q  <= req_waddr;
        delay_q  <= req_delay;
        opf_q    <= req_op_func;
      end
      // The counter is loaded on the edge entering EXEC so that it already
      // holds the latched delay during the exec_start cycle; a zero delay
      // therefore samples the result on that very cycle.
      if (state_q == ST_WAIT_RD) begin
        for (int k = 0; k < 3; k++) begin
          opnd_q[k*DATA_W +: DATA_W] <= rvalid_q[k] ? sram_rdata[k*DATA_W +: DATA_W]
                                                    : {DATA_W{1'b0}};
        end
        cnt_q   <= delay_q;
        start_q <= 1'b1;
      end else begin
        start_q <= 1'b0;
      end
      if (state_q == ST_EXEC) begin
        if (cnt_q == {MAX_DELAY_LG2{1'b0}}) begin
          result_q <= exec_result;
        end else begin
          cnt_q <= cnt_q - MAX_DELAY_LG2'(1);
        end
      end
    end
  end

  // Output decode; every output is held at zero while reset is asserted
  always_comb begin
    req_ready    = 1'b0;
    sram_ren     = 3'b000;
    sram_raddr   = {(3*ADDR_W){1'b0}};
    exec_start   = 1'b0;
    exec_op_func = {OPF_W{1'b0}};
    exec_opnd    = {(3*DATA_W){1'b0}};
    sram_wen     = 1'b0;
    sram_waddr   = {ADDR_W{1'b0}};
    sram_wdata   = {DATA_W{1'b0}};
    done         = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: req_ready = 1'b1;
        ST_READ: begin
          sram_ren = rvalid_q;
          // Disabled ports present a zero address
          for (int k = 0; k < 3; k++) begin
            sram_raddr[k*ADDR_W +: ADDR_W] = rvalid_q[k] ? raddr_q[k*ADDR_W +: ADDR_W]
                                                         : {ADDR_W{1'b0}};
          end
        end
        ST_WAIT_RD: req_ready = 1'b0;
        ST_EXEC: begin
          exec_start   = start_q;
          exec_op_func = opf_q;
          exec_opnd    = opnd_q;
        end
        ST_WRITE: begin
          sram_wen   = 1'b1;
          sram_waddr = waddr_q;
          sram_wdata = result_q;
          done       = 1'b1;
        end
        default: req_ready = 1'b0;
      endcase
    end else begin
      req_ready = 1'b0;
    end
  end

`ifdef VPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt_q;

  // Completed-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt_q <= 32'd0;
    end else if (state_q == ST_WRITE) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end else begin
      perf_cnt_q <= perf_cnt_q;
    end
  end

  assign perf_cnt = rst_n ? perf_cnt_q : 32'd0;
`else
  assign perf_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_vpu_exec_sequencer.sv
module tb_vpu_exec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_rvalid;
  logic [23:0] req_raddr;
  logic [7:0]  req_waddr;
  logic [2:0]  req_delay;
  logic [15:0] req_op_func;
  logic [2:0]  sram_ren;
  logic [23:0] sram_raddr;
  logic [95:0] sram_rdata;
  logic        exec_start;
  logic [15:0] exec_op_func;
  logic [95:0] exec_opnd;
  logic [31:0] exec_result;
  logic        sram_wen;
  logic [7:0]  sram_waddr;
  logic [31:0] sram_wdata;
  logic        done;
  logic [31:0] perf_cnt;

  int checks;
  int failures;
  logic [31:0] exp_perf;
  logic [39:0] sb_q[$];   // {waddr, wdata} expected per accepted instruction

`ifdef VPU_SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  vpu_exec_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rvalid   (req_rvalid),
    .req_raddr    (req_raddr),
    .req_waddr    (req_waddr),
    .req_delay    (req_delay),
    .req_op_func  (req_op_func),
    .sram_ren     (sram_ren),
    .sram_raddr   (sram_raddr),
    .sram_rdata   (sram_rdata),
    .exec_start   (exec_start),
    .exec_op_func (exec_op_func),
    .exec_opnd    (exec_opnd),
    .exec_result  (exec_result),
    .sram_wen     (sram_wen),
    .sram_waddr   (sram_waddr),
    .sram_wdata   (sram_wdata),
    .done         (done),
    .perf_cnt     (perf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h5A5A_0000 + {24'd0, a};
  endfunction

  // SRAM read model: one-cycle latency, garbage on disabled ports
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sram_ren[k]) sram_rdata[k*32 +: 32] <= mem_word(sram_raddr[k*8 +: 8]);
      else             sram_rdata[k*32 +: 32] <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction; called at a negedge with the DUT idle, returns at
  // the negedge of the first idle cycle after the write.
  task automatic run_instr(input logic [2:0] rv, input logic [23:0] ra, input logic [7:0] wa,
                           input logic [2:0] dl, input logic [15:0] opf, input logic [31:0] res);
    logic [95:0] exp_opnd;
    logic [23:0] exp_ra;
    logic [39:0] ent;
    int last;
    for (int k = 0; k < 3; k++) begin
      exp_opnd[k*32 +: 32] = rv[k] ? mem_word(ra[k*8 +: 8]) : 32'd0;
      exp_ra[k*8 +: 8]     = rv[k] ? ra[k*8 +: 8] : 8'd0;
    end
    last = int'(dl) + 4;
    chk("idle_ready", 128'(req_ready), 128'(1'b1));
    req_valid = 1'b1; req_rvalid = rv; req_raddr = ra; req_waddr = wa;
    req_delay = dl; req_op_func = opf;
    @(posedge clk);
    sb_q.push_back({wa, res});
    @(negedge clk);
    // Junk on the request bus must be ignored while busy
    req_valid = 1'b0; req_rvalid = 3'b111; req_raddr = 24'hFFFFFF;
    req_waddr = 8'hEE; req_delay = 3'd7; req_op_func = 16'hFFFF;
    for (int c = 1; c <= last; c++) begin
      chk("ctrl", 128'({req_ready, sram_ren, exec_start, sram_wen, done}),
          128'({1'b0, (c == 1) ? rv : 3'b000, c == 3, c == last, c == last}));
      if (c == 1) chk("raddr", 128'(sram_raddr), 128'(exp_ra));
      else        chk("raddr_idle", 128'(sram_raddr), 128'(24'd0));
      if (c >= 3 && c < last) begin
        chk("opnd", 128'(exec_opnd), 128'(exp_opnd));
        chk("opf", 128'(exec_op_func), 128'(opf));
        exec_result = (c - 3 == int'(dl)) ? res : ~res;
      end else begin
        exec_result = 32'hBAD0_0000;
      end
      if (sram_wen) begin
        chk("sb_nonempty", 128'(sb_q.size() != 0), 128'(1'b1));
        if (sb_q.size() != 0) begin
          ent = sb_q.pop_front();
          chk("waddr", 128'(sram_waddr), 128'(ent[39:32]));
          chk("wdata", 128'(sram_wdata), 128'(ent[31:0]));
        end
      end else begin
        chk("wr_bus_idle", 128'({sram_waddr, sram_wdata}), 128'(40'd0));
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (PERF_EN) exp_perf = exp_perf + 32'd1;
    chk("perf", 128'(perf_cnt), 128'(exp_perf));
    chk("ready_back", 128'(req_ready), 128'(1'b1));
  endtask

  initial begin
    int acc[$];
    int n_wen;
    checks = 0; failures = 0; exp_perf = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_rvalid = 3'b000; req_raddr = 24'd0;
    req_waddr = 8'd0; req_delay = 3'd0; req_op_func = 16'd0; exec_result = 32'd0;
    sram_rdata = 96'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 128'({req_ready, sram_ren, exec_start, sram_wen, done, perf_cnt}), 128'(39'd0));
    chk("rst_bus", 128'({sram_raddr, sram_waddr, sram_wdata, exec_op_func}), 128'(80'd0));
    chk("rst_opnd", 128'(exec_opnd), 128'(96'd0));
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 128'(req_ready), 128'(1'b1));
    @(negedge clk);

    // Two read ports, delay 1
    run_instr(3'b011, {8'd0, 8'd5, 8'd4}, 8'd9, 3'd1, 16'h0004, 32'h0000_00AB);
    // Zero delay, single read port
    run_instr(3'b001, {8'd7, 8'd6, 8'd3}, 8'd20, 3'd0, 16'h0001, 32'h1234_5678);
    // No read ports at all
    run_instr(3'b000, {8'd1, 8'd2, 8'd3}, 8'd33, 3'd2, 16'h0100, 32'hCAFE_F00D);
    // All ports, maximum delay
    run_instr(3'b111, {8'd200, 8'd100, 8'd50}, 8'd255, 3'd7, 16'h8000, 32'hFFFF_0001);

    // req_valid held high with delay 7: accepts every 12 cycles
    req_valid = 1'b1; req_rvalid = 3'b101; req_raddr = {8'd9, 8'd8, 8'd7};
    req_waddr = 8'd3; req_delay = 3'd7; req_op_func = 16'h0010; exec_result = 32'h77;
    n_wen = 0;
    for (int c = 0; c < 36; c++) begin
      if (req_ready) acc.push_back(c);
      if (sram_wen) n_wen++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_accepts", 128'(acc.size()), 128'(3));
    if (acc.size() == 3) begin
      chk("bp_gap1", 128'(acc[1] - acc[0]), 128'(12));
      chk("bp_gap2", 128'(acc[2] - acc[1]), 128'(12));
    end
    chk("bp_writes", 128'(n_wen), 128'(3));
    if (PERF_EN) exp_perf = exp_perf + 32'd3;
    chk("bp_perf", 128'(perf_cnt), 128'(exp_perf));
    chk("bp_ready", 128'(req_ready), 128'(1'b1));

`ifdef VPU_SEQ_PERF_CNT_EN
    // Counter wrap
    force dut.perf_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.perf_cnt_q;
    chk("perf_forced", 128'(perf_cnt), 128'(32'hFFFF_FFFF));
    exp_perf = 32'hFFFF_FFFF;
    run_instr(3'b010, {8'd0, 8'd11, 8'd0}, 8'd44, 3'd3, 16'h0002, 32'h0BAD_CAFE);
`endif

    // Reset during EXEC aborts the instruction
    req_valid = 1'b1; req_rvalid = 3'b111; req_raddr = {8'd1, 8'd2, 8'd3};
    req_waddr = 8'd66; req_delay = 3'd5; req_op_func = 16'h0040;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_in_exec", 128'(exec_op_func), 128'(16'h0040));
    rst_n = 1'b0;
    #1;
    chk("abort_rst_outs", 128'({req_ready, sram_ren, exec_start, sram_wen, done, perf_cnt}), 128'(39'd0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_perf = 32'd0;
    chk("abort_ready", 128'(req_ready), 128'(1'b1));
    chk("abort_perf", 128'(perf_cnt), 128'(32'd0));
    n_wen = 0;
    for (int c = 0; c < 10; c++) begin
      if (sram_wen || done) n_wen++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_write", 128'(n_wen), 128'(0));

    // Traffic after reset still works
    run_instr(3'b100, {8'd77, 8'd0, 8'd0}, 8'd1, 3'd4, 16'h0020, 32'h0000_0042);

    chk("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
